// File: rtl/mem_responder.sv
// Word-addressed memory slave for the multicycle controller: serves Mem_Read/Mem_Write
// with a fixed access latency and returns a one-cycle mem_ready pulse per access.
module mem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Read,
    input  logic        Mem_Write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        busy,
    output logic        proto_err,
    output logic        misalign_err
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        RELEASE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                op_write;
    logic [ADDR_W-1:0]   word_addr;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we_c;
    logic                unused_addr_bits;

    // Byte offset and bits above the word index do not select storage.
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    // The array write happens on the completion edge; a reset in flight suppresses it.
    assign mem_we_c = (state == BUSY) && (cnt == '0) && op_write && !reset;

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[word_addr] <= wdata_q;
        end
    end

    // Access sequencer; mem_ready and proto_err are single-cycle registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            op_write     <= 1'b0;
            word_addr    <= '0;
            wdata_q      <= '0;
            read_data    <= '0;
            mem_ready    <= 1'b0;
            busy         <= 1'b0;
            proto_err    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (Mem_Read ^ Mem_Write) begin
                        op_write  <= Mem_Write;
                        word_addr <= addr[ADDR_W+1:2];
                        wdata_q   <= write_data;
                        cnt       <= CNT_W'(LATENCY - 1);
                        busy      <= 1'b1;
                        state     <= BUSY;
                        if (addr[1:0] != 2'b00) begin
                            misalign_err <= 1'b1;
                        end
                    end else if (Mem_Read && Mem_Write) begin
                        proto_err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!op_write) begin
                            read_data <= mem[word_addr];
                        end
                        mem_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= RELEASE;
                end
                RELEASE: begin
                    // A strobe still held from the finished access must drop before re-arming.
                    if (!Mem_Read && !Mem_Write) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed memory slave that serves the multicycle controller's Mem_Read/Mem_Write strobes with a fixed, parameterised access latency.
- Sits on the datapath memory port, after the IorD address mux. Returns read_data plus a one-cycle mem_ready pulse, so the controller can stall in its memory states until the access completes.
- One memory serves both instruction fetch and lw/sw.

Parameters:
- ADDR_W, 8, number of word-address bits used (addr[ADDR_W+1:2]).
- DEPTH, 256, number of 32-bit words; must equal 2**ADDR_W.
- LATENCY, 2, clock edges from request acceptance to access completion; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Mem_Read  in  1  read request level from controller.
- Mem_Write  in  1  write request level from controller.
- addr  in  32  byte address; must be word aligned.
- write_data  in  32  store data.
- read_data  out  32  registered read result; held until the next read completes.
- mem_ready  out  1  one-cycle pulse when an access completes.
- busy  out  1  high in BUSY and DONE states.
- proto_err  out  1  one-cycle pulse when Mem_Read and Mem_Write are sampled high together in IDLE.
- misalign_err  out  1  sticky flag, set when a request is accepted with addr[1:0]!=0.

Behaviour:
- Reset (async, active-high) forces: state=IDLE, cnt=0, read_data=0, mem_ready=0, proto_err=0, misalign_err=0, busy=0. Any pending access is discarded and no array write occurs. Array contents are not reset.
- States: IDLE, BUSY, DONE, RELEASE.
- IDLE, exactly one of Mem_Read/Mem_Write high at an edge:
  - latch op, addr[ADDR_W+1:2] and write_data;
  - cnt <= LATENCY-1; go to BUSY;
  - if addr[1:0]!=0, set misalign_err; the access still uses the aligned word.
- IDLE, both Mem_Read and Mem_Write high: no access, proto_err=1 for the following cycle, stay in IDLE.
- IDLE, neither high: stay in IDLE.
- BUSY, cnt>0: cnt decrements each edge.
- BUSY, edge with cnt==0:
  - write: array[latched addr] <= latched data;
  - read: read_data <= array[latched addr];
  - go to DONE; mem_ready=1 for the cycle in DONE.
- Timing consequence: mem_ready is high in the cycle after edge E0+LATENCY, where E0 is the accept edge. Read data is valid in that same cycle.
- Request inputs are ignored during BUSY. Dropping a request mid-BUSY does not cancel the access.
- DONE lasts exactly one cycle, then RELEASE.
- RELEASE holds until Mem_Read=Mem_Write=0 at an edge, then IDLE. One idle cycle is therefore required between accesses, which prevents a held controller strobe from being served twice.
- busy is high in BUSY and DONE only.
- mem_ready and proto_err are registered; there is no combinational path from input to output.
- Writes never alter read_data.
- The address wraps modulo DEPTH; upper address bits are ignored.

Test Plan:
- LATENCY=2, after reset: pulse Mem_Write with addr=0x00000010, write_data=0xDEADBEEF, drop the strobe after mem_ready; then Mem_Read at 0x10 -> mem_ready high in the 3rd cycle after the accept edge and read_data=0xDEADBEEF in that same cycle; read_data=0 before that read.
- Mem_Read held high for 10 cycles at addr 0x0 -> exactly one mem_ready pulse; the responder stays in RELEASE, busy=0; after the strobe drops for 1 cycle, a new request is accepted.
- Mem_Read=Mem_Write=1 in IDLE -> proto_err=1 for one cycle, no mem_ready, array unchanged (read-back of the previous value confirms).
- Request with addr=0x00000013 -> misalign_err=1 and stays 1; the access hits word 4. A subsequent aligned access keeps misalign_err=1 until reset.
- Assert reset during BUSY of a write of 0x12345678 to 0x20 -> all outputs 0 immediately (async); a later read of 0x20 returns the pre-write value.
- Address wrap: write 0xA5A5A5A5 at addr 0x00000400 (word 256) with ADDR_W=8 -> read at 0x0 returns 0xA5A5A5A5.
